// File: rtl/sc8_ctrl_pkg.sv
// Shared control definitions for the SC8 instruction sequencer:
// FSM state encoding, default halt opcode and execute-step counter width.
package sc8_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_DECODE,
      ST_EXEC,
      ST_HALT
   } seq_state_e;

   localparam logic [3:0]  HLT_OPCODE_DEFAULT = 4'hF;
   localparam int unsigned TSTATE_W           = 3;

endpackage

// File: rtl/step_counter.sv
// Execute-step counter: counts EXEC cycles and flags the last step.
// Clear has priority over enable; the count never passes EXEC_STEPS-1.
module step_counter
   import sc8_ctrl_pkg::*;
#(
   parameter int unsigned EXEC_STEPS = 3
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                clr_i,
   input  logic                en_i,
   output logic [TSTATE_W-1:0] cnt_o,
   output logic                last_o
);

   localparam logic [TSTATE_W-1:0] LAST_STEP = TSTATE_W'(EXEC_STEPS - 1);

   logic [TSTATE_W-1:0] cnt_q, cnt_d;

   // Next count: clear wins, otherwise advance while enabled and not at the last step.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && !last_o) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Count register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o  = cnt_q;
   assign last_o = (cnt_q == LAST_STEP);

endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer: FETCH -> DECODE -> EXEC loop with halt.
// Latches the fetched byte into IR; opcode/operand feed the control decoder,
// op_valid/tstate qualify its outputs. All outputs come from registers.
// Optional macro SEQ_SINGLE_STEP_EN adds a 'step' input gating EXEC progress.
module instr_sequencer
   import sc8_ctrl_pkg::*;
#(
   parameter int unsigned EXEC_STEPS = 3,
   parameter logic [3:0]  HLT_OPCODE = HLT_OPCODE_DEFAULT
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                run,
`ifdef SEQ_SINGLE_STEP_EN
   input  logic                step,
`endif
   input  logic [7:0]          mem_data,
   input  logic                mem_ready,
   output logic                fetch_req,
   output logic [3:0]          opcode,
   output logic [3:0]          operand,
   output logic                op_valid,
   output logic [TSTATE_W-1:0] tstate,
   output logic                halted
);

   seq_state_e state_q, state_d;
   logic [7:0] ir_q, ir_d;
   logic       fetch_req_q, op_valid_q, halted_q;
   logic       step_en, step_clr, step_last;

   // EXEC progresses every cycle, or only on step pulses in single-step builds.
`ifdef SEQ_SINGLE_STEP_EN
   assign step_en = (state_q == ST_EXEC) && step;
`else
   assign step_en = (state_q == ST_EXEC);
`endif
   // Counter is held at zero outside EXEC and cleared as EXEC is left.
   assign step_clr = (state_q != ST_EXEC) || (step_en && step_last);

   step_counter #(
      .EXEC_STEPS (EXEC_STEPS)
   ) u_step_counter (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr_i  (step_clr),
      .en_i   (step_en),
      .cnt_o  (tstate),
      .last_o (step_last)
   );

   // Next-state and IR load decisions; run is only looked at in IDLE and the last EXEC step.
   always_comb begin
      state_d = state_q;
      ir_d    = ir_q;
      case (state_q)
         ST_IDLE: begin
            if (run) state_d = ST_FETCH;
         end
         ST_FETCH: begin
            if (mem_ready) begin
               ir_d    = mem_data;
               state_d = ST_DECODE;
            end
         end
         ST_DECODE: begin
            state_d = ST_EXEC;
         end
         ST_EXEC: begin
            if (step_en && step_last) begin
               if (ir_q[7:4] == HLT_OPCODE) state_d = ST_HALT;
               else if (run)                state_d = ST_FETCH;
               else                         state_d = ST_IDLE;
            end
         end
         ST_HALT: begin
            state_d = ST_HALT;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, IR and registered outputs decoded from the upcoming state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         ir_q        <= 8'h00;
         fetch_req_q <= 1'b0;
         op_valid_q  <= 1'b0;
         halted_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         ir_q        <= ir_d;
         fetch_req_q <= (state_d == ST_FETCH);
         op_valid_q  <= (state_d == ST_DECODE) || (state_d == ST_EXEC);
         halted_q    <= (state_d == ST_HALT);
      end
   end

   assign fetch_req = fetch_req_q;
   assign op_valid  = op_valid_q;
   assign halted    = halted_q;
   assign opcode    = ir_q[7:4];
   assign operand   = ir_q[3:0];

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed testbench for instr_sequencer (default parameters).
// Define SEQ_SINGLE_STEP_EN for both DUT and bench to exercise the step input.
module tb_instr_sequencer;

   logic       clk;
   logic       rst_n;
   logic       run;
   logic [7:0] mem_data;
   logic       mem_ready;
   logic       fetch_req;
   logic [3:0] opcode;
   logic [3:0] operand;
   logic       op_valid;
   logic [2:0] tstate;
   logic       halted;
`ifdef SEQ_SINGLE_STEP_EN
   logic       step;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   instr_sequencer dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .run       (run),
`ifdef SEQ_SINGLE_STEP_EN
      .step      (step),
`endif
      .mem_data  (mem_data),
      .mem_ready (mem_ready),
      .fetch_req (fetch_req),
      .opcode    (opcode),
      .operand   (operand),
      .op_valid  (op_valid),
      .tstate    (tstate),
      .halted    (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string tag, input logic fr, input logic ov,
                          input logic [2:0] ts, input logic hl);
      chk({tag, ".fetch_req"}, fetch_req, fr);
      chk({tag, ".op_valid"},  op_valid,  ov);
      chk({tag, ".tstate"},    tstate,    ts);
      chk({tag, ".halted"},    halted,    hl);
   endtask

   initial begin
      rst_n     = 1'b0;
      run       = 1'b0;
      mem_data  = 8'h00;
      mem_ready = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
      step      = 1'b1;
`endif

      // Reset: outputs stay zero even with run and mem_ready active.
      tick();
      run = 1'b1; mem_ready = 1'b1; mem_data = 8'hA5;
      tick();
      tick();
      chk_out("rst", 1'b0, 1'b0, 3'd0, 1'b0);
      chk("rst.opcode",  opcode,  4'h0);
      chk("rst.operand", operand, 4'h0);
      mem_ready = 1'b0;
      rst_n = 1'b1;

      // First cycle after release is FETCH.
      tick();
      chk_out("start", 1'b1, 1'b0, 3'd0, 1'b0);

      // Zero-wait fetch of 8'h3A.
      mem_data = 8'h3A; mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      chk_out("zw.decode", 1'b0, 1'b1, 3'd0, 1'b0);
      chk("zw.opcode",  opcode,  4'h3);
      chk("zw.operand", operand, 4'hA);
      tick();
      chk_out("zw.exec0", 1'b0, 1'b1, 3'd0, 1'b0);
      mem_data = 8'h55; mem_ready = 1'b1;      // ignored outside FETCH
      tick();
      mem_ready = 1'b0;
      chk_out("zw.exec1", 1'b0, 1'b1, 3'd1, 1'b0);
      chk("zw.ir_hold", opcode, 4'h3);
      tick();
      chk_out("zw.exec2", 1'b0, 1'b1, 3'd2, 1'b0);
      tick();
      chk_out("zw.refetch", 1'b1, 1'b0, 3'd0, 1'b0);

      // Wait states: acknowledge arrives on the 4th FETCH cycle.
      mem_data = 8'h7C;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("ws.fetch_req", fetch_req, 1'b1);
         chk("ws.ir_hold",   opcode,    4'h3);
      end
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      chk_out("ws.decode", 1'b0, 1'b1, 3'd0, 1'b0);
      chk("ws.opcode",  opcode,  4'h7);
      chk("ws.operand", operand, 4'hC);

      // run dropped during EXEC step 1: instruction completes, then IDLE.
      tick();
      tick();
      chk("rd.exec1", tstate, 3'd1);
      run = 1'b0;
      tick();
      chk_out("rd.exec2", 1'b0, 1'b1, 3'd2, 1'b0);
      tick();
      chk_out("rd.idle", 1'b0, 1'b0, 3'd0, 1'b0);
      tick();
      chk_out("rd.idle2", 1'b0, 1'b0, 3'd0, 1'b0);
      run = 1'b1;
      tick();
      chk_out("rd.restart", 1'b1, 1'b0, 3'd0, 1'b0);

      // Halt instruction 8'hF0.
      mem_data = 8'hF0; mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      chk("hlt.opcode", opcode, 4'hF);
      tick();
      tick();
      tick();
      chk_out("hlt.exec2", 1'b0, 1'b1, 3'd2, 1'b0);
      tick();
      chk_out("hlt.halt", 1'b0, 1'b0, 3'd0, 1'b1);
      mem_data = 8'h12;
      for (int i = 0; i < 4; i++) begin
         run       = i[0];
         mem_ready = 1'b1;
         tick();
         chk_out("hlt.stay", 1'b0, 1'b0, 3'd0, 1'b1);
         chk("hlt.ir_hold", {opcode, operand}, 8'hF0);
      end
      mem_ready = 1'b0;
      run = 1'b1;
      rst_n = 1'b0;
      #2;
      chk("hlt.rst_clear", halted, 1'b0);
      #1;
      rst_n = 1'b1;
      tick();
      chk_out("hlt.after_rst", 1'b1, 1'b0, 3'd0, 1'b0);

      // Load 8'h5A and come back around to FETCH, then reset asynchronously.
      mem_data = 8'h5A; mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      tick();
      tick();
      tick();
      tick();
      chk_out("ar.fetch", 1'b1, 1'b0, 3'd0, 1'b0);
      chk("ar.ir_before", {opcode, operand}, 8'h5A);
      rst_n = 1'b0;
      #2;
      chk_out("ar.fetch_rst", 1'b0, 1'b0, 3'd0, 1'b0);
      chk("ar.ir_rst", {opcode, operand}, 8'h00);
      #1;
      rst_n = 1'b1;

      // Async reset during EXEC step 1 drops op_valid and tstate at once.
      tick();
      mem_data = 8'h96; mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      tick();
      tick();
      chk_out("ae.exec1", 1'b0, 1'b1, 3'd1, 1'b0);
      rst_n = 1'b0;
      #2;
      chk_out("ae.rst", 1'b0, 1'b0, 3'd0, 1'b0);
      chk("ae.ir_rst", {opcode, operand}, 8'h00);
      #1;
      rst_n = 1'b1;

`ifdef SEQ_SINGLE_STEP_EN
      // Single-step: EXEC only advances on step pulses.
      tick();
      chk("ss.fetch", fetch_req, 1'b1);
      mem_data = 8'h21; mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      step = 1'b0;
      tick();
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_out("ss.hold0", 1'b0, 1'b1, 3'd0, 1'b0);
      end
      step = 1'b1;
      tick();
      step = 1'b0;
      chk_out("ss.step1", 1'b0, 1'b1, 3'd1, 1'b0);
      tick();
      chk_out("ss.hold1", 1'b0, 1'b1, 3'd1, 1'b0);
      step = 1'b1;
      tick();
      step = 1'b0;
      chk_out("ss.step2", 1'b0, 1'b1, 3'd2, 1'b0);
      tick();
      chk_out("ss.hold2", 1'b0, 1'b1, 3'd2, 1'b0);
      step = 1'b1;
      tick();
      chk_out("ss.refetch", 1'b1, 1'b0, 3'd0, 1'b0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
